// File: rtl/conv_pkg.sv
// Shared types and constants for the 2-D convolution window sequencer.
// Holds the FSM state encoding, TableBuffer geometry and datapath widths,
// and the packed payload carried on the result port.
package conv_pkg;

   localparam int unsigned TB_DIM    = 4;
   localparam int unsigned TB_ADDR_W = 2;
   localparam int unsigned DATA_W    = 8;
   localparam int unsigned ACC_W     = 20;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      MAC  = 3'd2,
      EMIT = 3'd3,
      DONE = 3'd4
   } conv_state_e;

   // Result payload: sum plus the output position it belongs to
   typedef struct packed {
      logic [ACC_W-1:0]     data;
      logic [TB_ADDR_W-1:0] row;
      logic [TB_ADDR_W-1:0] col;
   } conv_result_t;

endpackage

// File: rtl/conv_mac.sv
// Multiply-accumulate for one convolution window.
// Build option: CONV_SIGNED_EN makes pixels/kernel two's complement and the
// product sign-extended; otherwise everything is unsigned.
// Ports:
//   clk, rst          clock, async active-high reset
//   en_i              accumulate this cycle
//   first_i           first step of a window: restart the sum from the product
//   img_px_i/ker_px_i operands
//   sum_c_o           combinational running sum including this cycle's product
module conv_mac
   import conv_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              en_i,
   input  logic              first_i,
   input  logic [DATA_W-1:0] img_px_i,
   input  logic [DATA_W-1:0] ker_px_i,
   output logic [ACC_W-1:0]  sum_c_o
);

   localparam int unsigned PROD_W = 2 * DATA_W;

   logic [ACC_W-1:0] prod_ext;
   logic [ACC_W-1:0] acc_q;

   // Product, widened to the accumulator
`ifdef CONV_SIGNED_EN
   logic signed [PROD_W-1:0] prod_s;
   always_comb begin
      prod_s   = $signed(img_px_i) * $signed(ker_px_i);
      prod_ext = {{(ACC_W-PROD_W){prod_s[PROD_W-1]}}, prod_s};
   end
`else
   logic [PROD_W-1:0] prod_u;
   always_comb begin
      prod_u   = img_px_i * ker_px_i;
      prod_ext = ACC_W'(prod_u);
   end
`endif

   assign sum_c_o = first_i ? prod_ext : (acc_q + prod_ext);

   // Accumulator
   always_ff @(posedge clk or posedge rst) begin
      if (rst)       acc_q <= '0;
      else if (en_i) acc_q <= sum_c_o;
   end

endmodule

// File: rtl/conv_window_ctrl.sv
// Sequencer for one 2-D convolution pass over a 4x4 image TableBuffer.
// Loads image and kernel buffers, walks each KxK window in raster order,
// accumulates via conv_mac, and streams (4-K+1)^2 results over valid/ready.
// Build option: CONV_SIGNED_EN (selects signed MAC arithmetic in conv_mac).
// Ports:
//   clk, rst                    clock, async active-high reset
//   start / busy / done         pass control
//   img_ld, ker_ld              buffer load strobes
//   img_row/img_col, ker_row/ker_col  registered read addresses
//   img_px, ker_px              combinational buffer read data
//   out_data/out_row/out_col/out_valid/out_ready  result stream
module conv_window_ctrl
   import conv_pkg::*;
#(
   parameter int unsigned K = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   output logic                 busy,
   output logic                 done,
   output logic                 img_ld,
   output logic                 ker_ld,
   output logic [TB_ADDR_W-1:0] img_row,
   output logic [TB_ADDR_W-1:0] img_col,
   output logic [TB_ADDR_W-1:0] ker_row,
   output logic [TB_ADDR_W-1:0] ker_col,
   input  logic [DATA_W-1:0]    img_px,
   input  logic [DATA_W-1:0]    ker_px,
   output logic [ACC_W-1:0]     out_data,
   output logic [TB_ADDR_W-1:0] out_row,
   output logic [TB_ADDR_W-1:0] out_col,
   output logic                 out_valid,
   input  logic                 out_ready
);

   localparam int unsigned NOUT = TB_DIM - K + 1;
   localparam logic [TB_ADDR_W-1:0] KMAX = TB_ADDR_W'(K - 1);
   localparam logic [TB_ADDR_W-1:0] NMAX = TB_ADDR_W'(NOUT - 1);

   conv_state_e          state_q, state_d;
   logic [TB_ADDR_W-1:0] kr_q, kr_d, kc_q, kc_d;
   logic [TB_ADDR_W-1:0] img_row_q, img_col_q;
   conv_result_t         res_q, res_d;
   logic                 valid_q, valid_d;
   logic                 busy_q, done_q, ld_q;
   logic                 mac_en_c, first_c, last_c;
   logic [ACC_W-1:0]     sum_c;

   assign first_c = (kr_q == '0) && (kc_q == '0);
   assign last_c  = (res_q.row == NMAX) && (res_q.col == NMAX);

   conv_mac u_mac (
      .clk      (clk),
      .rst      (rst),
      .en_i     (mac_en_c),
      .first_i  (first_c),
      .img_px_i (img_px),
      .ker_px_i (ker_px),
      .sum_c_o  (sum_c)
   );

   // Next-state, window walk and result capture
   always_comb begin
      state_d  = state_q;
      kr_d     = kr_q;
      kc_d     = kc_q;
      res_d    = res_q;
      valid_d  = valid_q;
      mac_en_c = 1'b0;
      unique case (state_q)
         IDLE: if (start) state_d = LOAD;
         LOAD: begin
            state_d   = MAC;
            kr_d      = '0;
            kc_d      = '0;
            res_d.row = '0;
            res_d.col = '0;
         end
         MAC: begin
            mac_en_c = 1'b1;
            if (kc_q == KMAX) begin
               kc_d = '0;
               if (kr_q == KMAX) begin
                  kr_d       = '0;
                  res_d.data = sum_c;
                  valid_d    = 1'b1;
                  state_d    = EMIT;
               end else begin
                  kr_d = kr_q + TB_ADDR_W'(1);
               end
            end else begin
               kc_d = kc_q + TB_ADDR_W'(1);
            end
         end
         EMIT: if (out_ready) begin
            valid_d = 1'b0;
            if (last_c) begin
               state_d = DONE;
            end else begin
               state_d = MAC;
               if (res_q.col == NMAX) begin
                  res_d.col = '0;
                  res_d.row = res_q.row + TB_ADDR_W'(1);
               end else begin
                  res_d.col = res_q.col + TB_ADDR_W'(1);
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and registered outputs; status flags are decoded from next state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         kr_q      <= '0;
         kc_q      <= '0;
         res_q     <= '0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         ld_q      <= 1'b0;
         img_row_q <= '0;
         img_col_q <= '0;
      end else begin
         state_q   <= state_d;
         kr_q      <= kr_d;
         kc_q      <= kc_d;
         res_q     <= res_d;
         valid_q   <= valid_d;
         busy_q    <= (state_d != IDLE);
         done_q    <= (state_d == DONE);
         ld_q      <= (state_d == LOAD);
         img_row_q <= res_d.row + kr_d;
         img_col_q <= res_d.col + kc_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign img_ld    = ld_q;
   assign ker_ld    = ld_q;
   assign img_row   = img_row_q;
   assign img_col   = img_col_q;
   assign ker_row   = kr_q;
   assign ker_col   = kc_q;
   assign out_data  = res_q.data;
   assign out_row   = res_q.row;
   assign out_col   = res_q.col;
   assign out_valid = valid_q;

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Directed bench for conv_window_ctrl (K=3) with behavioural TableBuffers.
module tb_conv_window_ctrl;
   import conv_pkg::*;

   logic              clk = 1'b0;
   logic              rst, start, out_ready;
   logic              busy, done, img_ld, ker_ld, out_valid;
   logic [1:0]        img_row, img_col, ker_row, ker_col, out_row, out_col;
   logic [7:0]        img_px, ker_px;
   logic [19:0]       out_data;

   logic [7:0] img_mem [16];
   logic [7:0] ker_mem [16];
   logic [7:0] img_stage [16];
   logic [7:0] ker_stage [16];

   int n_cmp = 0;
   int n_err = 0;
   int ld_cnt = 0;
   int done_cnt = 0;
   int lat, gap;

`ifdef CONV_SIGNED_EN
   localparam logic [19:0] EXP_FF = 20'hFFFF7;
`else
   localparam logic [19:0] EXP_FF = 20'd2295;
`endif

   always #5 clk = ~clk;

   conv_window_ctrl #(.K(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .img_ld    (img_ld),
      .ker_ld    (ker_ld),
      .img_row   (img_row),
      .img_col   (img_col),
      .ker_row   (ker_row),
      .ker_col   (ker_col),
      .img_px    (img_px),
      .ker_px    (ker_px),
      .out_data  (out_data),
      .out_row   (out_row),
      .out_col   (out_col),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   // TableBuffer models: capture on load strobe, combinational read
   always @(posedge clk) begin
      if (img_ld) for (int i = 0; i < 16; i++) img_mem[i] <= img_stage[i];
      if (ker_ld) for (int i = 0; i < 16; i++) ker_mem[i] <= ker_stage[i];
   end
   assign img_px = img_mem[{img_row, img_col}];
   assign ker_px = ker_mem[{ker_row, ker_col}];

   always @(negedge clk) begin
      if (img_ld) ld_cnt++;
      if (done)   done_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk(tag, {busy, done, img_ld, ker_ld, img_row, img_col, ker_row, ker_col,
                out_row, out_col, out_valid}, 0);
      chk({tag, "_data"}, out_data, 0);
   endtask

   task automatic stage(input logic [7:0] iv, input bit ramp, input bit center_only);
      for (int i = 0; i < 16; i++) begin
         img_stage[i] = ramp ? 8'(i) : iv;
         ker_stage[i] = center_only ? ((i == 5) ? 8'd1 : 8'd0) : 8'd1;
      end
   endtask

   // One full pass; stall_len cycles of out_ready=0 on result 0
   task automatic do_pass(input logic [19:0] e0, e1, e2, e3, input int stall_len,
                          input bit restart_mid, output int lat0, output int gap01);
      logic [19:0] e [4];
      int idx, cyc, stall, ld0, dn0;
      e = '{e0, e1, e2, e3};
      idx = 0; cyc = 0; stall = stall_len; lat0 = -1; gap01 = -1;
      ld0 = ld_cnt; dn0 = done_cnt;
      chk("idle_busy", busy, 0);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("busy_on", busy, 1);
      while (idx < 4 && cyc < 300) begin
         @(posedge clk); #1;
         cyc++;
         start = restart_mid && (cyc == 3);
         out_ready = 1'b1;
         if (out_valid) begin
            if (idx == 0 && lat0 < 0) lat0 = cyc;
            if (idx == 1 && gap01 < 0) gap01 = cyc - lat0;
            if (idx == 0 && stall > 0) begin
               out_ready = 1'b0;
               stall--;
               chk("hold_data", out_data, e[0]);
               chk("hold_pos", {out_row, out_col}, 0);
               chk("hold_ker", {ker_row, ker_col}, 0);
            end else begin
               chk($sformatf("data%0d", idx), out_data, e[idx]);
               chk($sformatf("row%0d", idx), out_row, idx / 2);
               chk($sformatf("col%0d", idx), out_col, idx % 2);
               idx++;
            end
         end
      end
      chk("results", idx, 4);
      @(posedge clk); #1;
      chk("done_hi", done, 1);
      chk("busy_in_done", busy, 1);
      @(posedge clk); #1;
      chk("done_lo", done, 0);
      chk("busy_off", busy, 0);
      chk("done_pulses", done_cnt - dn0, 1);
      chk("ld_pulses", ld_cnt - ld0, 1);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         img_mem[i] = 8'd0;
         ker_mem[i] = 8'd0;
      end
      rst = 1'b1; start = 1'b0; out_ready = 1'b1;
      stage(8'd1, 1'b0, 1'b0);
      @(posedge clk); @(posedge clk); #1;
      chk_all_zero("reset");
      rst = 1'b0;
      @(posedge clk); #1;

      // all ones image and kernel
      do_pass(20'd9, 20'd9, 20'd9, 20'd9, 0, 1'b0, lat, gap);
      chk("lat_ones", lat, 10);

      // start re-pulsed mid-MAC is ignored
      do_pass(20'd9, 20'd9, 20'd9, 20'd9, 0, 1'b1, lat, gap);

      // ramp image, centre-tap kernel: latency and per-result spacing
      stage(8'd0, 1'b1, 1'b1);
      do_pass(20'd5, 20'd6, 20'd9, 20'd10, 0, 1'b0, lat, gap);
      chk("lat_ramp", lat, 10);
      chk("gap_ramp", gap, 10);

      // back-pressure on result 0
      do_pass(20'd5, 20'd6, 20'd9, 20'd10, 5, 1'b0, lat, gap);

      // reset during step 4 of result 1
      stage(8'd1, 1'b0, 1'b0);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (15) begin @(posedge clk); #1; end
      chk("mid_ker", {ker_row, ker_col}, {2'd1, 2'd1});
      chk("mid_pos", {out_row, out_col}, {2'd0, 2'd1});
      chk("mid_img", {img_row, img_col}, {2'd1, 2'd2});
      rst = 1'b1;
      #1;
      chk_all_zero("abort");
      @(posedge clk); #1;
      chk_all_zero("abort_next");
      rst = 1'b0;
      @(posedge clk); #1;
      do_pass(20'd9, 20'd9, 20'd9, 20'd9, 0, 1'b0, lat, gap);
      chk("lat_after_rst", lat, 10);

      // saturated image
      stage(8'hFF, 1'b0, 1'b0);
      do_pass(EXP_FF, EXP_FF, EXP_FF, EXP_FF, 0, 1'b0, lat, gap);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
